sdam_tx: RTL and testbench

Serial transmitter for the single-wire-data / single-clock address+data frame format; it is the sending end for the SDAM receiver. Accepts an 8-bit address and 16-bit data word over a valid/ready handshake. Serializes them onto scl/sda as a framed transfer: start bit, marker bit, address LSB-first, data LSB-first. Sits on the host side and drives the link into the receiver block.

---
 rtl/sdam_tx.sv | 147 ++++++++++++++
 tb/tb_sdam_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdam_tx.sv
// sdam_tx: serial transmitter for the SDAM address+data frame on scl/sda.
// Frame: start 0, marker 1, addr LSB-first, data LSB-first; sda only moves on scl fall events.
module sdam_tx #(
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_addr,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        scl,
    output logic        sda,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned PH_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
    localparam logic [4:0]       BIT_LAST = 5'd25;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        SEND,
        GAP
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic              r_scl;
    logic              r_sda;
    logic              r_busy;
    logic              r_tx_done;
    logic              r_in_ready;
    logic [4:0]        r_bit_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [23:0]       r_shift;

    logic              w_tick;
    logic              w_fall;
    logic [GAP_W-1:0]  w_gap_next;

    assign w_tick     = (r_phase == PH_LAST);
    assign w_fall     = w_tick & r_scl;
    assign w_gap_next = r_gap_cnt + GAP_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_scl   <= 1'b0;
        end else if (w_tick) begin
            r_phase <= '0;
            r_scl   <= ~r_scl;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // The final gap bit is supplied by the IDLE -> WAIT_EDGE alignment, so GAP
    // releases one fall event early and back-to-back frames see exactly GAP_BITS
    // high bits; with GAP_BITS==1 the GAP state is skipped altogether.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_sda      <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_sda <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_shift    <= {in_data, in_addr};
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= WAIT_EDGE;
                    end
                end
                WAIT_EDGE: begin
                    if (w_fall) begin
                        r_sda     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_fall) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_sda     <= 1'b1;
                            r_tx_done <= 1'b1;
                            r_gap_cnt <= '0;
                            if (GAP_BITS == 1) begin
                                r_busy     <= 1'b0;
                                r_in_ready <= 1'b1;
                                r_state    <= IDLE;
                            end else begin
                                r_state <= GAP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd0) begin
                                r_sda <= 1'b1;
                            end else begin
                                r_sda   <= r_shift[0];
                                r_shift <= {1'b0, r_shift[23:1]};
                            end
                        end
                    end
                end
                GAP: begin
                    r_sda <= 1'b1;
                    if (w_fall) begin
                        r_gap_cnt <= w_gap_next;
                        if (w_gap_next == GAP_LAST) begin
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_sda      <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign scl      = r_scl;
    assign sda      = r_sda;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_sdam_tx.sv
// tb_sdam_tx: directed bench for sdam_tx with a bit-level receiver model and frame scoreboard.
// Instance A: HALF_DIV=4, GAP_BITS=2; instance B: HALF_DIV=1, GAP_BITS=2.
module tb_sdam_tx;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_valid, a_ready, a_scl, a_sda, a_busy, a_done;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic        b_valid, b_ready, b_scl, b_sda, b_busy, b_done;
    logic [7:0]  b_addr;
    logic [15:0] b_data;

    sdam_tx #(.HALF_DIV(4), .GAP_BITS(2)) u_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_addr(a_addr),
        .in_data(a_data), .in_ready(a_ready), .scl(a_scl), .sda(a_sda),
        .busy(a_busy), .tx_done(a_done)
    );

    sdam_tx #(.HALF_DIV(1), .GAP_BITS(2)) u_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_addr(b_addr),
        .in_data(b_data), .in_ready(b_ready), .scl(b_scl), .sda(b_sda),
        .busy(b_busy), .tx_done(b_done)
    );

    logic scl_v[2], sda_v[2], rdy_v[2], done_v[2];
    assign scl_v[0] = a_scl;   assign scl_v[1] = b_scl;
    assign sda_v[0] = a_sda;   assign sda_v[1] = b_sda;
    assign rdy_v[0] = a_ready; assign rdy_v[1] = b_ready;
    assign done_v[0] = a_done; assign done_v[1] = b_done;

    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    int          m_st[2], m_cnt[2], m_hi[2], m_gap[2], m_frames[2], m_done[2], m_viol[2];
    logic        m_prev[2], m_psda[2], m_pdone[2];
    logic [23:0] m_sh[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic finish_frame(input int k);
        logic [23:0] e;
        if (k == 0) begin
            chk("A frame expected", exp_a.size() != 0, 1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                chk("A frame addr/data", m_sh[0], e);
            end
        end else begin
            chk("B frame expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                chk("B frame addr/data", m_sh[1], e);
            end
        end
        m_frames[k]++;
    endtask

    // Receiver model: samples sda on every scl rise, watching the link between rises.
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_cnt[k] = 0; m_hi[k] = 0;
                m_prev[k] = 1'b0; m_psda[k] = 1'b1; m_pdone[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sda_v[k] !== m_psda[k] && !(m_prev[k] && !scl_v[k])) m_viol[k]++;
                if (rdy_v[k] && m_st[k] != 0) m_viol[k]++;
                if (done_v[k]) begin
                    m_done[k]++;
                    if (m_pdone[k]) m_viol[k]++;
                end
                if (scl_v[k] && !m_prev[k]) begin
                    case (m_st[k])
                        0: begin
                            if (!sda_v[k]) begin
                                m_gap[k] = m_hi[k];
                                m_st[k]  = 1;
                            end else begin
                                m_hi[k]++;
                            end
                        end
                        1: begin
                            chk(k == 0 ? "A marker" : "B marker", sda_v[k], 1);
                            m_st[k]  = 2;
                            m_cnt[k] = 0;
                        end
                        default: begin
                            m_sh[k] = {sda_v[k], m_sh[k][23:1]};
                            m_cnt[k]++;
                            if (m_cnt[k] == 24) begin
                                finish_frame(k);
                                m_st[k] = 0;
                                m_hi[k] = 0;
                            end
                        end
                    endcase
                end
                m_prev[k]  = scl_v[k];
                m_psda[k]  = sda_v[k];
                m_pdone[k] = done_v[k];
            end
        end
    end

    task automatic send(input int k, input logic [7:0] ad, input logic [15:0] da);
        int t = 0;
        while (!(k == 0 ? a_ready : b_ready) && t < 1000) begin @(negedge clk); t++; end
        if (k == 0) begin
            a_valid = 1'b1; a_addr = ad; a_data = da; exp_a.push_back({da, ad});
        end else begin
            b_valid = 1'b1; b_addr = ad; b_data = da; exp_b.push_back({da, ad});
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk(k == 0 ? "A ready low after accept" : "B ready low after accept",
            k == 0 ? a_ready : b_ready, 0);
    endtask

    task automatic wait_frames(input int k, input int n, input int budget);
        int t = 0;
        while (m_frames[k] < n && t < budget) begin @(negedge clk); t++; end
        chk(k == 0 ? "A frame count" : "B frame count", m_frames[k], n);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int t = 0;
        while (!(k == 0 ? a_ready : b_ready) && t < budget) begin @(negedge clk); t++; end
        chk(k == 0 ? "A ready after gap" : "B ready after gap", k == 0 ? a_ready : b_ready, 1);
        chk(k == 0 ? "A busy after gap" : "B busy after gap", k == 0 ? a_busy : b_busy, 0);
    endtask

    initial begin
        int cnt, guard, lat, wid;
        reset_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        repeat (3) @(negedge clk);
        chk("A reset scl", a_scl, 0);
        chk("A reset sda", a_sda, 1);
        chk("A reset busy", a_busy, 0);
        chk("A reset tx_done", a_done, 0);
        chk("A reset in_ready", a_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frame
        send(0, 8'h5A, 16'hA53C);
        wait_frames(0, 1, 600);
        wait_idle(0, 200);
        chk("A tx_done pulses frame 1", m_done[0], 1);

        // Accept in the same cycle as a fall event
        cnt = 0; guard = 0;
        while (cnt < 4 && guard < 100) begin
            @(negedge clk);
            if (a_scl) cnt++; else cnt = 0;
            guard++;
        end
        a_valid = 1'b1; a_addr = 8'h3C; a_data = 16'hC0DE; exp_a.push_back({16'hC0DE, 8'h3C});
        @(negedge clk);
        a_valid = 1'b0;
        chk("A accept coincides with fall", a_scl, 0);
        lat = 0;
        while (a_sda !== 1'b0 && lat < 100) begin @(negedge clk); lat++; end
        chk("A accept-to-start clk", lat, 8);
        wid = 0;
        while (a_sda === 1'b0 && wid < 100) begin @(negedge clk); wid++; end
        chk("A start bit width clk", wid, 8);
        wait_frames(0, 2, 600);
        wait_idle(0, 200);

        // in_valid pulsed mid-frame is ignored
        send(0, 8'h96, 16'h0F0F);
        guard = 0;
        while (!(m_st[0] == 2 && m_cnt[0] >= 4) && guard < 400) begin @(negedge clk); guard++; end
        chk("A ready low mid-frame", a_ready, 0);
        a_valid = 1'b1; a_addr = 8'h33; a_data = 16'h3333;
        @(negedge clk);
        a_valid = 1'b0;
        wait_frames(0, 3, 600);
        repeat (400) @(negedge clk);
        chk("A no extra frame", m_frames[0], 3);
        chk("A tx_done pulses after 3", m_done[0], 3);

        // Back-to-back with in_valid held
        a_valid = 1'b1; a_addr = 8'h01; a_data = 16'h0001; exp_a.push_back({16'h0001, 8'h01});
        guard = 0;
        while (a_ready !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        a_addr = 8'hFF; a_data = 16'hFFFF; exp_a.push_back({16'hFFFF, 8'hFF});
        guard = 0;
        while (a_ready !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        guard = 0;
        while (a_ready !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        a_valid = 1'b0;
        wait_frames(0, 5, 1200);
        chk("A back-to-back gap bits", m_gap[0], 2);
        wait_idle(0, 200);

        // Reset during bit 12
        send(0, 8'hE7, 16'h5555);
        guard = 0;
        while (!(m_st[0] == 2 && m_cnt[0] >= 10) && guard < 400) begin @(negedge clk); guard++; end
        reset_n = 1'b0;
        #1;
        chk("A mid-frame reset scl", a_scl, 0);
        chk("A mid-frame reset sda", a_sda, 1);
        chk("A mid-frame reset busy", a_busy, 0);
        chk("A mid-frame reset in_ready", a_ready, 1);
        exp_a.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, 8'hC3, 16'h1234);
        wait_frames(0, 6, 600);
        wait_idle(0, 200);

        // HALF_DIV=1
        send(1, 8'h80, 16'h8000);
        wait_frames(1, 1, 200);
        wait_idle(1, 50);
        chk("B tx_done pulses", m_done[1], 1);

        chk("A link violations", m_viol[0], 0);
        chk("B link violations", m_viol[1], 0);
        chk("A scoreboard drained", exp_a.size(), 0);
        chk("B scoreboard drained", exp_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
